// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter that serialises writes
// into a single enable-register bank.
package dff_bank_arbiter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // Round-robin pick: first set bit searching upward from ptr, wrapping at n.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i < n) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_bank.sv
// Shared register storage: WIDTH enable flip-flops with async active-low reset.
module dff_bank
  import dff_bank_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage register, loaded only when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter: grants one requester, latches its data, writes it into
// the shared bank for one cycle and acknowledges; fixed 4-cycle transaction.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [IDXW-1:0]  winner_q, winner_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  pick_s;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             bank_en_s;

  assign pick_s = IDXW'(rr_pick(8'(req), 3'(ptr_q), N_REQ));

  // Next-state, winner/pointer/hold updates and registered-output decode.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          state_d  = ST_GRANT;
          winner_d = pick_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        hold_d = wdata[winner_q*WIDTH +: WIDTH];
        // A winner that withdrew before the write aborts without moving ptr.
        if (req[winner_q]) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ptr_d   = (winner_q == IDXW'(N_REQ - 1)) ? '0 : winner_q + IDXW'(1);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    gnt_d  = ((state_d == ST_GRANT) || (state_d == ST_WRITE)) ? (ONE << winner_d) : '0;
    ack_d  = (state_d == ST_ACK) ? (ONE << winner_d) : '0;
    busy_d = (state_d != ST_IDLE);
  end

  // State, arbitration bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign bank_en_s = (state_q == ST_WRITE);

  dff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .en  (bank_en_s),
    .d   (hold_q),
    .q   (q)
  );

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-age reference model of the arbiter.
module tb_dff_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   q;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_age = cycles into the current transaction (0 = idle).
  int       m_age, m_win, m_ptr;
  logic [W-1:0] m_q, m_hold;

  int       ack_idx[$];
  int       ack_cyc[$];
  int       cyc = 0;
  logic [W-1:0] q_saved;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (p + i) % N;
      if (r[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_age = 0; m_win = 0; m_ptr = 0; m_q = '0; m_hold = '0;
  endtask

  task automatic model_step();
    case (m_age)
      0: if (req != '0) begin m_win = rr_ref(req, m_ptr); m_age = 1; end
      1: begin
        m_hold = wdata[m_win*W +: W];
        m_age  = req[m_win] ? 2 : 0;
      end
      2: begin m_q = m_hold; m_age = 3; end
      default: begin m_ptr = (m_win + 1) % N; m_age = 0; end
    endcase
  endtask

  task automatic check_outputs(input string pfx);
    logic [N-1:0] eg, ea;
    eg = (m_age == 1 || m_age == 2) ? N'(1 << m_win) : '0;
    ea = (m_age == 3) ? N'(1 << m_win) : '0;
    check({pfx, "_gnt"},  32'(gnt),  32'(eg));
    check({pfx, "_ack"},  32'(ack),  32'(ea));
    check({pfx, "_q"},    32'(q),    32'(m_q));
    check({pfx, "_busy"}, 32'(busy), 32'(m_age != 0));
    check({pfx, "_excl"}, 32'($onehot0(gnt) && $onehot0(ack) && !((|gnt) && (|ack))), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    cyc++;
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1 check_outputs("por");

    // Single requester, fixed latency.
    apply_reset();
    req = 4'b0001; wdata[7:0] = 8'hA5;
    cycle(); check("t1_gnt1", 32'(gnt), 32'h1);
    cycle(); check("t1_gnt2", 32'(gnt), 32'h1);
    cycle(); check("t1_q", 32'(q), 32'hA5); check("t1_ack", 32'(ack), 32'h1);
    req = '0;
    cycle(); check("t1_busy", 32'(busy), 32'h0); check("t1_ack_off", 32'(ack), 32'h0);

    // All requesting: rotation 0,1,2,3,0 at 4-cycle spacing.
    apply_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      cycle();
      for (int b = 0; b < N; b++) begin
        if (ack[b]) begin
          ack_idx.push_back(b);
          ack_cyc.push_back(cyc);
          check("t2_qdata", 32'(q), 32'(wdata[b*W +: W]));
        end
      end
    end
    req = '0;
    check("t2_count", 32'(ack_idx.size()), 32'd5);
    for (int k = 0; k < ack_idx.size() && k < 5; k++) begin
      check("t2_order", 32'(ack_idx[k]), 32'(k % N));
      if (k > 0) check("t2_period", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
    end

    // Wrap-around: after granting 1, ptr=2 and 0011 picks 0.
    apply_reset();
    req = 4'b0010;
    repeat (4) cycle();
    req = 4'b0011;
    cycle(); check("t3_wrap", 32'(gnt), 32'h1);
    repeat (3) cycle();
    req = '0;

    // Abort in GRANT leaves ptr and q alone; same requester wins again.
    apply_reset();
    wdata = {8'h44, 8'h5A, 8'h22, 8'h3C};
    req = 4'b0010;
    repeat (4) cycle();
    q_saved = q;
    req = 4'b0101;
    cycle(); check("t4_gnt", 32'(gnt), 32'h4);
    req = 4'b0001;
    cycle();
    check("t4_idle", 32'(busy), 32'h0);
    check("t4_noack", 32'(ack), 32'h0);
    check("t4_qhold", 32'(q), 32'(q_saved));
    req = 4'b0101;
    cycle(); check("t4_regrant", 32'(gnt), 32'h4);
    repeat (3) cycle();
    req = '0;
    cycle();
    check("t4_qwrite", 32'(q), 32'h5A);

    // Asynchronous reset in the middle of WRITE.
    req = 4'b0001;
    cycle();
    cycle();
    check("t5_inwrite", 32'(gnt), 32'h1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t5_q0", 32'(q), 32'h0);
    check("t5_gnt0", 32'(gnt), 32'h0);
    check("t5_busy0", 32'(busy), 32'h0);
    req = '0;
    cycle();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("t5_noack", 32'(ack), 32'h0);
    end

    // Random traffic against the model.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req   = N'($urandom_range(0, 15));
      wdata = N*W'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
